// File: rtl/top_level.sv
// -----------------------------------------------------------------------------
// top_level -- SECDED (extended Hamming 16,11) block decoder
//
// Purpose:
//   Reads fifteen 16-bit codewords from data memory (core[30..59], little
//   endian), decodes each one with single-error correction and double-error
//   detection, and writes fifteen 16-bit result words {flags, 3'b000, data}
//   back to core[0..29]. The job runs once after reset and then holds done.
//
// Ports:
//   clk    in  1  clock, all state updates on the rising edge
//   reset  in  1  synchronous active-high reset; restarts the decode job
//   done   out 1  high once all 15 words are written, held until reset
//
// Hierarchy:
//   dm1 (data_mem) holds core[0:255] x 8 bit, reachable as dm1.core[n] for
//   preload and readback.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// data_mem -- 256 x 8 byte memory, combinational read, synchronous write
//
// Ports:
//   clk    in  1  clock
//   we     in  1  write enable, one byte per rising edge
//   addr   in  8  shared read/write address
//   wdata  in  8  write data
//   rdata  out 8  combinational read data at addr
// -----------------------------------------------------------------------------
module data_mem (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);

    logic [7:0] core [0:255];

    assign rdata = core[addr];

    // NOTE: the array has no reset branch on purpose: contents loaded before
    // reset must survive it, and a reset on an array would also stop it from
    // mapping onto RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            core[addr] <= wdata;
        end
    end

endmodule

module top_level (
    input  logic clk,
    input  logic reset,
    output logic done
);

    typedef enum logic [2:0] {
        S_LOAD_LO  = 3'd0,
        S_LOAD_HI  = 3'd1,
        S_DECODE   = 3'd2,
        S_STORE_LO = 3'd3,
        S_STORE_HI = 3'd4,
        S_NEXT     = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    localparam logic [3:0] LAST_WORD = 4'd14;
    localparam logic [7:0] IN_BASE   = 8'd30;

    state_t      state;
    state_t      next_state;

    logic [3:0]  idx;         // current word number 0..14
    logic [15:0] codeword;    // assembled input codeword
    logic [15:0] result;      // registered decoded output word
    logic [15:0] decoded;     // combinational decoder output

    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [7:0]  word_offset;

    data_mem dm1 (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update together from pre-edge values; blocking '=' here would make the
    // result depend on statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_LOAD_LO;
        end else begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state logic
    // -------------------------------------------------------------------------
    // NOTE: each combinational block assigns its outputs a default before any
    // branching, so no path leaves a signal unassigned and no latch appears.
    always_comb begin
        next_state = state;
        unique case (state)
            S_LOAD_LO:  next_state = S_LOAD_HI;
            S_LOAD_HI:  next_state = S_DECODE;
            S_DECODE:   next_state = S_STORE_LO;
            S_STORE_LO: next_state = S_STORE_HI;
            S_STORE_HI: next_state = S_NEXT;
            S_NEXT:     next_state = (idx < LAST_WORD) ? S_LOAD_LO : S_DONE;
            S_DONE:     next_state = S_DONE;
            default:    next_state = S_LOAD_LO;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM outputs: memory address / write strobe / write data and done.
    // Writes and done are masked while reset is high so an aborted job never
    // writes and done reads low for the whole reset window.
    // -------------------------------------------------------------------------
    assign word_offset = {3'b000, idx, 1'b0};

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = 8'd0;
        mem_wdata = 8'd0;
        done      = 1'b0;
        unique case (state)
            S_LOAD_LO:  mem_addr = IN_BASE + word_offset;
            S_LOAD_HI:  mem_addr = IN_BASE + word_offset + 8'd1;
            S_STORE_LO: begin
                mem_addr  = word_offset;
                mem_wdata = result[7:0];
                mem_we    = !reset;
            end
            S_STORE_HI: begin
                mem_addr  = word_offset + 8'd1;
                mem_wdata = result[15:8];
                mem_we    = !reset;
            end
            S_DONE:     done = !reset;
            default:    ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers: codeword assembly, decoded result, word counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            idx <= 4'd0;
        end else begin
            unique case (state)
                S_LOAD_LO: codeword[7:0]  <= mem_rdata;
                S_LOAD_HI: codeword[15:8] <= mem_rdata;
                S_DECODE:  result         <= decoded;
                S_NEXT:    if (idx < LAST_WORD) idx <= idx + 4'd1;
                default:   ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // SECDED decoder.
    // Syndrome is the XOR of the positions of all set bits; a single error
    // always flips overall parity, so parity=1 means "correct bit s" (s=0 is
    // the overall parity bit itself), while parity=0 with s!=0 is a double
    // error that is flagged but left uncorrected.
    // -------------------------------------------------------------------------
    always_comb begin
        logic [3:0]  syndrome;
        logic        parity;
        logic [15:0] corrected;
        logic [1:0]  flags;

        syndrome = 4'd0;
        for (int k = 1; k < 16; k++) begin
            if (codeword[k]) begin
                syndrome = syndrome ^ 4'(k);
            end
        end
        parity    = ^codeword;
        corrected = codeword;
        flags     = 2'b00;

        if (parity) begin
            corrected[syndrome] = ~codeword[syndrome];
            flags               = 2'b01;
        end else if (syndrome != 4'd0) begin
            flags = 2'b10;
        end

        // Data bits sit at positions 15:9 (d11..d5), 7:5 (d4..d2), 3 (d1).
        decoded = {flags, 3'b000, corrected[15:9], corrected[7:5], corrected[3]};
    end

endmodule

// File: tb/tb_top_level.sv
// -----------------------------------------------------------------------------
// tb_top_level -- self-checking bench for the SECDED block decoder.
// Expected outputs come from how each codeword was built: a clean encoding of
// random data plus a known number of injected bit flips.
// -----------------------------------------------------------------------------
module tb_top_level;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] cw_in   [15];
    logic [15:0] exp_out [15];

    always #5 clk = ~clk;

    top_level dut (
        .clk   (clk),
        .reset (reset),
        .done  (done)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Places the 11 data bits into their codeword slots.
    function automatic logic [15:0] place_data(input logic [10:0] d);
        logic [15:0] w;
        w = 16'h0000;
        w[3]    = d[0];
        w[7:5]  = d[3:1];
        w[15:9] = d[10:4];
        return w;
    endfunction

    function automatic logic [10:0] extract(input logic [15:0] w);
        return {w[15:9], w[7:5], w[3]};
    endfunction

    // Builds a clean extended-Hamming codeword for d.
    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] w;
        logic [3:0]  s;
        w = place_data(d);
        s = 4'd0;
        for (int k = 1; k < 16; k++) if (w[k]) s = s ^ 4'(k);
        w[1] = s[0];
        w[2] = s[1];
        w[4] = s[2];
        w[8] = s[3];
        w[0] = ^w;
        return w;
    endfunction

    // One random flip, plus a second distinct flip a quarter of the time.
    task automatic make_random_word(input int i);
        logic [10:0] d;
        logic [15:0] cw;
        int f1;
        int f2;
        d  = 11'($urandom);
        cw = encode(d);
        f1 = int'($urandom_range(15, 0));
        cw = cw ^ (16'd1 << f1);
        if ($urandom_range(3, 0) == 0) begin
            f2 = (f1 + int'($urandom_range(15, 1))) % 16;
            cw = cw ^ (16'd1 << f2);
            exp_out[i] = {2'b10, 3'b000, extract(cw)};
        end else begin
            exp_out[i] = {2'b01, 3'b000, d};
        end
        cw_in[i] = cw;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 15; i++) make_random_word(i);
    endtask

    task automatic preload();
        for (int i = 0; i < 15; i++) begin
            dut.dm1.core[30 + 2*i] = cw_in[i][7:0];
            dut.dm1.core[31 + 2*i] = cw_in[i][15:8];
        end
        for (int a = 0; a < 30; a++) dut.dm1.core[a] = 8'hAA;
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check({tag, " done low in reset"}, 16'(done), 16'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check({tag, " done low after start"}, 16'(done), 16'd0);
    endtask

    task automatic run_to_done(input string tag);
        int cyc;
        cyc = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " done within 200 cycles"}, 16'(done), 16'd1);
    endtask

    task automatic check_outputs(input string tag);
        for (int i = 0; i < 15; i++) begin
            check($sformatf("%s out word %0d", tag, i),
                  {dut.dm1.core[2*i + 1], dut.dm1.core[2*i]}, exp_out[i]);
            check($sformatf("%s input word %0d kept", tag, i),
                  {dut.dm1.core[31 + 2*i], dut.dm1.core[30 + 2*i]}, cw_in[i]);
        end
    endtask

    initial begin
        // Job 1: directed vectors in words 0..4, random single/double errors after.
        fill_random();
        cw_in[0] = 16'h0000; exp_out[0] = 16'h0000;
        cw_in[1] = 16'h0008; exp_out[1] = 16'h4000;
        cw_in[2] = 16'hFFFF; exp_out[2] = 16'h07FF;
        cw_in[3] = 16'hFFFE; exp_out[3] = 16'h47FF;
        cw_in[4] = 16'h0006; exp_out[4] = 16'h8000;
        preload();
        apply_reset("job1");
        run_to_done("job1");
        check_outputs("job1");
        check("job1 double-error msb", 16'(dut.dm1.core[9][7]), 16'd1);
        repeat (20) @(negedge clk);
        check("job1 done held", 16'(done), 16'd1);

        // Job 2: reset from DONE drops done and reruns on fresh random data.
        fill_random();
        preload();
        apply_reset("job2");
        run_to_done("job2");
        check_outputs("job2");
        repeat (10) @(negedge clk);
        check("job2 done held", 16'(done), 16'd1);

        // Job 3: reset pulsed mid-job; rerun must match an uninterrupted decode.
        fill_random();
        preload();
        apply_reset("job3");
        repeat (40) @(negedge clk);
        check("job3 done low mid-job", 16'(done), 16'd0);
        reset = 1'b1;
        @(negedge clk);
        check("job3 done low in mid-job reset", 16'(done), 16'd0);
        reset = 1'b0;
        @(negedge clk);
        check("job3 done low after restart", 16'(done), 16'd0);
        run_to_done("job3");
        check_outputs("job3");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/top_level.md
TOP_LEVEL -- requirements
Module: top_level

Interface
REQ-001 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high; restarts the decode job.
REQ-004 done  output  1  high when all 15 words are decoded and written; held high until the next reset.
REQ-005 The block SHALL contain a data memory instance named dm1 holding an array named core of 256 x 8-bit entries, directly accessible hierarchically (DUT.dm1.core[n]) for preload and readback.

Function
REQ-006 Input word i (i = 0..14) SHALL be a 16-bit codeword: low byte at core[30+2i], high byte at core[31+2i].
REQ-007 Codeword bit positions SHALL be: bit0 = p0, bit1 = p1, bit2 = p2, bit3 = d1, bit4 = p4, bits7:5 = d4..d2, bit8 = p8, bits15:9 = d11..d5.
REQ-008 Syndrome s[3:0] SHALL equal the XOR of the indices (1..15) of all set codeword bits; overall parity P SHALL equal the XOR of all 16 bits.
REQ-009 If s = 0 and P = 0 (no error): flags = 2'b00, data = d11..d1 unchanged.
REQ-010 If P = 1 (single error): invert codeword bit s (s = 0 means p0 flipped, data unaffected); flags = 2'b01; data = corrected d11..d1.
REQ-011 If P = 0 and s != 0 (double error): flags = 2'b10; data = uncorrected d11..d1.
REQ-012 Output word i SHALL be {flags[1:0], 3'b000, d11..d1}: bits 7:0 written to core[2i], bits 15:8 to core[2i+1].
REQ-013 Words SHALL be processed in order i = 0..14 by an FSM: LOAD_LO -> LOAD_HI -> DECODE -> STORE_LO -> STORE_HI -> NEXT (i+1; go to LOAD_LO if i < 14, else DONE); DONE is terminal.
REQ-014 Memory reads SHALL be combinational; memory writes SHALL be synchronous, one byte per cycle.
REQ-015 done SHALL rise no later than 200 cycles after reset deasserts, and only after core[29] is written.
REQ-016 Only addresses 0..29 SHALL be written; addresses 30..59 SHALL remain unmodified.

Reset
REQ-017 While reset is high: FSM goes to LOAD_LO, i = 0, done = 0; processing starts on the first clock with reset low.
REQ-018 Reset SHALL NOT clear dm1.core, so data preloaded before reset is preserved.
REQ-019 Reset asserted mid-job SHALL abort the job and restart from word 0 with done = 0; partially written outputs are overwritten by the rerun.
REQ-020 Reset asserted while in DONE SHALL drop done and rerun the job.

Verification
REQ-021 Codeword 0x0000 (no error) -> output 0x0000 (core[1] = 0x00, core[0] = 0x00).
REQ-022 Codeword 0x0008 (d1 flipped in 0x0000) -> output 0x4000.
REQ-023 Codeword 0xFFFF (data 0x7FF, clean) -> output 0x07FF; codeword 0xFFFE (p0 flipped) -> output 0x47FF.
REQ-024 Codeword 0x0006 (p1 and p2 flipped in 0x0000) -> output MSB (core[2i+1] bit 7) = 1.
REQ-025 15 random codewords, each with one flip plus, 25% of the time, a second flip: 15/15 correct; done is held high; core[30..59] is unchanged.
REQ-026 Pulse reset mid-job, then let the job finish -> done low until complete, with final outputs identical to an uninterrupted run.
